// File: rtl/calc1_pkg.sv
// Shared definitions for the four-port calc1 calculator: widths, command and
// response codes, the per-port state type and the combinational ALU.
package calc1_pkg;

   localparam int DW = 32;

   localparam logic [3:0] CMD_NONE = 4'd0;
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_SHL  = 4'd5;
   localparam logic [3:0] CMD_SHR  = 4'd6;

   localparam logic [1:0] RSP_NONE = 2'd0;
   localparam logic [1:0] RSP_OK   = 2'd1;
   localparam logic [1:0] RSP_ERR  = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OP2  = 1'b1
   } port_state_e;

   typedef struct packed {
      logic [1:0]    resp;
      logic [DW-1:0] data;
   } result_t;

   // Errors always return data 0; a wrapped or borrowed value never leaves the block.
   function automatic result_t alu(input logic [3:0] cmd,
                                   input logic [DW-1:0] a,
                                   input logic [DW-1:0] b);
      result_t     res;
      logic [DW:0] sum;
      logic [4:0]  shamt;
      res.resp = RSP_ERR;
      res.data = '0;
      sum      = {1'b0, a} + {1'b0, b};
      shamt    = b[4:0];
      case (cmd)
         CMD_ADD: if (!sum[DW]) begin
            res.resp = RSP_OK;
            res.data = sum[DW-1:0];
         end
         CMD_SUB: if (a >= b) begin
            res.resp = RSP_OK;
            res.data = a - b;
         end
         CMD_SHL: begin
            res.resp = RSP_OK;
            res.data = a << shamt;
         end
         CMD_SHR: begin
            res.resp = RSP_OK;
            res.data = a >> shamt;
         end
         default: ;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/calc1_port.sv
// One requester port: IDLE/OP2 sequencer, operand-1 and command capture,
// and a registered one-cycle response pulse.
module calc1_port
   import calc1_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [0:3]    cmd_in,
   input  logic [0:DW-1] data_in,
   output logic [0:DW-1] data_out,
   output logic [0:1]    resp_out
);

   port_state_e   state_q, state_d;
   logic [3:0]    cmd_q, cmd_d;
   logic [DW-1:0] op1_q, op1_d;
   logic [1:0]    resp_q, resp_d;
   logic [DW-1:0] data_q, data_d;
   result_t       res;

   // Bus ports number bit 0 as the MSB; numeric values cross unchanged.
   assign res = alu(cmd_q, op1_q, data_in);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      op1_d   = op1_q;
      resp_d  = RSP_NONE;
      data_d  = '0;
      case (state_q)
         ST_IDLE: if (cmd_in != CMD_NONE) begin
            cmd_d   = cmd_in;
            op1_d   = data_in;
            state_d = ST_OP2;
         end
         ST_OP2: begin
            resp_d  = res.resp;
            data_d  = res.data;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignment so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cmd_q   <= CMD_NONE;
         op1_q   <= '0;
         resp_q  <= RSP_NONE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         op1_q   <= op1_d;
         resp_q  <= resp_d;
         data_q  <= data_d;
      end
   end

   assign data_out = data_q;
   assign resp_out = resp_q;

endmodule

// File: rtl/calc1_core.sv
// calc1 top: four independent calculator ports sharing only clock and reset.
module calc1_core
   import calc1_pkg::*;
(
   output logic [0:DW-1] out_data1,
   output logic [0:DW-1] out_data2,
   output logic [0:DW-1] out_data3,
   output logic [0:DW-1] out_data4,
   output logic [0:1]    out_resp1,
   output logic [0:1]    out_resp2,
   output logic [0:1]    out_resp3,
   output logic [0:1]    out_resp4,
   input  logic          c_clk,
   input  logic [0:3]    req1_cmd_in,
   input  logic [0:DW-1] req1_data_in,
   input  logic [0:3]    req2_cmd_in,
   input  logic [0:DW-1] req2_data_in,
   input  logic [0:3]    req3_cmd_in,
   input  logic [0:DW-1] req3_data_in,
   input  logic [0:3]    req4_cmd_in,
   input  logic [0:DW-1] req4_data_in,
   input  logic          reset
);

   calc1_port u_port1 (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd_in   (req1_cmd_in),
      .data_in  (req1_data_in),
      .data_out (out_data1),
      .resp_out (out_resp1)
   );

   calc1_port u_port2 (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd_in   (req2_cmd_in),
      .data_in  (req2_data_in),
      .data_out (out_data2),
      .resp_out (out_resp2)
   );

   calc1_port u_port3 (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd_in   (req3_cmd_in),
      .data_in  (req3_data_in),
      .data_out (out_data3),
      .resp_out (out_resp3)
   );

   calc1_port u_port4 (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd_in   (req4_cmd_in),
      .data_in  (req4_data_in),
      .data_out (out_data4),
      .resp_out (out_resp4)
   );

endmodule

// File: tb/tb_calc1_core.sv
// Self-checking bench for calc1_core: table-driven vectors plus hand sequences,
// with a cycle-stamped scoreboard checked on every falling edge for all four ports.
module tb_calc1_core;

   logic        clk;
   logic        rst_n;
   logic [0:3]  cmd  [4];
   logic [0:31] din  [4];
   logic [0:31] dout [4];
   logic [0:1]  resp [4];

   int n_checks;
   int n_fail;
   int cyc;

   typedef struct {
      int          port;
      int          due;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[17];

   calc1_core dut (
      .out_data1    (dout[0]),
      .out_data2    (dout[1]),
      .out_data3    (dout[2]),
      .out_data4    (dout[3]),
      .out_resp1    (resp[0]),
      .out_resp2    (resp[1]),
      .out_resp3    (resp[2]),
      .out_resp4    (resp[3]),
      .c_clk        (clk),
      .req1_cmd_in  (cmd[0]),
      .req1_data_in (din[0]),
      .req2_cmd_in  (cmd[1]),
      .req2_data_in (din[1]),
      .req3_cmd_in  (cmd[2]),
      .req3_data_in (din[2]),
      .req4_cmd_in  (cmd[3]),
      .req4_data_in (din[3]),
      .reset        (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [1:0] ar, input logic [31:0] ad,
                        input logic [1:0] er, input logic [31:0] ed);
      n_checks++;
      if (ar !== er || ad !== ed) begin
         n_fail++;
         $display("FAIL %s: got resp=%0d data=%h, expected resp=%0d data=%h", name, ar, ad, er, ed);
      end
   endtask

   // Every cycle, each port must show either its scheduled response or idle zeros.
   always @(negedge clk) begin : monitor
      logic [1:0]  er [4];
      logic [31:0] ed [4];
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         er[i] = 2'd0;
         ed[i] = 32'd0;
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.due == cyc) begin
            er[e.port] = e.resp;
            ed[e.port] = e.data;
         end else begin
            n_checks++;
            n_fail++;
            $display("FAIL stale expectation port%0d due %0d at cyc %0d", e.port + 1, e.due, cyc);
         end
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("port%0d cyc%0d", i + 1, cyc), resp[i], dout[i], er[i], ed[i]);
   end

   // Called just after a rising edge; returns just after the edge that samples operand 2,
   // so consecutive calls issue back-to-back.
   task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] r, input logic [31:0] d);
      cmd[p] = c;
      din[p] = a;
      sb.push_back('{port: p, due: cyc + 2, resp: r, data: d});
      @(posedge clk); #1;
      cmd[p] = 4'd0;
      din[p] = b;
      @(posedge clk); #1;
      din[p] = 32'd0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd[i] = 4'd0;
         din[i] = 32'd0;
      end

      vecs[0]  = '{0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
      vecs[1]  = '{0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE};
      vecs[2]  = '{0, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
      vecs[3]  = '{0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[4]  = '{0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000};
      vecs[5]  = '{0, 4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E};
      vecs[6]  = '{0, 4'd3, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[7]  = '{0, 4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
      vecs[8]  = '{0, 4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000};
      vecs[9]  = '{0, 4'd6, 32'h8000_0000, 32'h0000_0020, 2'd1, 32'h8000_0000};
      vecs[10] = '{1, 4'd6, 32'h8000_0000, 32'hFFFF_FFE4, 2'd1, 32'h0800_0000};
      vecs[11] = '{1, 4'd5, 32'h0000_000F, 32'h0000_0004, 2'd1, 32'h0000_00F0};
      vecs[12] = '{2, 4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
      vecs[13] = '{2, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 32'hFFFF_FFFF};
      vecs[14] = '{3, 4'd15, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0000_0000};
      vecs[15] = '{3, 4'd2, 32'h0000_0000, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
      vecs[16] = '{3, 4'd7, 32'hFFFF_FFFF, 32'h0000_0000, 2'd2, 32'h0000_0000};

      // Reset held for four cycles; the monitor expects all outputs at zero throughout.
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 17; v++)
         issue(vecs[v].port, vecs[v].cmd, vecs[v].a, vecs[v].b, vecs[v].resp, vecs[v].data);

      // Sweep of single-bit operands through add with zero, rotating over the ports.
      for (int k = 0; k < 15; k++)
         issue(k % 4, 4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k);

      // All four ports start together and must respond in the same cycle.
      cmd[0] = 4'd1; din[0] = 32'd2;
      cmd[1] = 4'd2; din[1] = 32'd10;
      cmd[2] = 4'd5; din[2] = 32'd1;
      cmd[3] = 4'd6; din[3] = 32'h100;
      sb.push_back('{port: 0, due: cyc + 2, resp: 2'd1, data: 32'd5});
      sb.push_back('{port: 1, due: cyc + 2, resp: 2'd1, data: 32'd6});
      sb.push_back('{port: 2, due: cyc + 2, resp: 2'd1, data: 32'h100});
      sb.push_back('{port: 3, due: cyc + 2, resp: 2'd1, data: 32'h10});
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) cmd[i] = 4'd0;
      din[0] = 32'd3;
      din[1] = 32'd4;
      din[2] = 32'd8;
      din[3] = 32'd4;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) din[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;

      // Reset arriving while port 1 waits for operand 2 must cancel the operation.
      cmd[0] = 4'd1;
      din[0] = 32'd7;
      @(posedge clk); #1;
      cmd[0] = 4'd0;
      din[0] = 32'd9;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      din[0] = 32'd0;
      @(posedge clk); #1;
      issue(0, 4'd1, 32'd7, 32'd9, 2'd1, 32'd16);

      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
